// File: rtl/logic_gate_unit.sv
// rtl/logic_gate_unit.sv - registered WIDTH-bit 8-function logic unit with valid/ready output, txn counter, optional self-test (SELFTEST_EN)
module logic_gate_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CNT_W-1:0] txn_count,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             sweep_err
);

    // Opcode table: 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 PASS A
    function automatic logic [WIDTH-1:0] gate_fn(
        input logic [2:0]       f_op,
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb
    );
        logic [WIDTH-1:0] r;
        case (f_op)
            3'b000:  r = ~(fa & fb);
            3'b001:  r = fa & fb;
            3'b010:  r = fa | fb;
            3'b011:  r = ~(fa | fb);
            3'b100:  r = fa ^ fb;
            3'b101:  r = ~(fa ^ fb);
            3'b110:  r = ~fa;
            default: r = fa;
        endcase
        return r;
    endfunction

    logic accept;
    logic handshake;

    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

`ifdef SELFTEST_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sweep_state_t;

    // Golden truth tables, one nibble per opcode (op 0 in the low nibble).
    // Within a nibble, bit {a,b} is the function output for that operand pair.
    localparam logic [31:0] GOLDEN = {
        4'b1100,  // PASS A
        4'b0011,  // NOT A
        4'b1001,  // XNOR
        4'b0110,  // XOR
        4'b0001,  // NOR
        4'b1110,  // OR
        4'b1000,  // AND
        4'b0111   // NAND
    };

    sweep_state_t     state;
    sweep_state_t     state_nxt;
    logic [4:0]       idx;
    logic             sweep_go;
    logic [2:0]       sw_op;
    logic [WIDTH-1:0] sw_a;
    logic [WIDTH-1:0] sw_b;
    logic [WIDTH-1:0] sw_res;
    logic [WIDTH-1:0] sw_exp;
    logic             sw_mismatch;

    assign sweep_go    = (state == ST_IDLE) && sweep_start && !out_valid;
    assign sw_op       = idx[4:2];
    assign sw_a        = {WIDTH{idx[1]}};
    assign sw_b        = {WIDTH{idx[0]}};
    assign sw_res      = gate_fn(sw_op, sw_a, sw_b);
    assign sw_exp      = {WIDTH{GOLDEN[idx]}};
    assign sw_mismatch = (sw_res != sw_exp);

    assign sweep_busy  = (state == ST_RUN);
    assign sweep_done  = (state == ST_DONE);

    // A launching sweep also blocks input so no result can land in y during RUN
    assign in_ready    = !sweep_busy && !sweep_go && (!out_valid || out_ready);

    // Sweep state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Sweep next-state: IDLE -> RUN (32 vectors) -> DONE (one cycle) -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (sweep_go) state_nxt = ST_RUN;
            ST_RUN:  if (idx == 5'd31) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Vector index and sticky mismatch flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 5'd0;
            sweep_err <= 1'b0;
        end else if (sweep_go) begin
            idx       <= 5'd0;
            sweep_err <= 1'b0;
        end else if (state == ST_RUN) begin
            idx <= idx + 5'd1;
            if (sw_mismatch) begin
                sweep_err <= 1'b1;
            end
        end
    end
`else
    logic unused_sweep_start;

    assign unused_sweep_start = sweep_start;
    assign sweep_busy         = 1'b0;
    assign sweep_done         = 1'b0;
    assign sweep_err          = 1'b0;
    assign in_ready           = !out_valid || out_ready;
`endif

    // One-deep output register: load on accept, clear valid on a bare drain, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= gate_fn(op, a, b);
        end else if (handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Count completed output handshakes, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (handshake) begin
            txn_count <= txn_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
